pll_rst_seq: RTL

PLL_RST_SEQ -- requirements
Module: pll_rst_seq

---
 rtl/pll_rst_seq_pkg.sv | 14 +
 rtl/pll_rst_seq_sync2.sv | 22 ++
 rtl/pll_rst_seq.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pll_rst_seq_pkg.sv
// Shared types for the PLL reset sequencer: state encoding and its width.
package pll_rst_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    PLLRST   = 3'd0,
    WAITLOCK = 3'd1,
    STABLE   = 3'd2,
    RUN      = 3'd3,
    FAIL     = 3'd4
  } state_t;

endpackage

// File: rtl/pll_rst_seq_sync2.sv
// Two-flop synchronizer bringing the PLL lock flag into the clkin domain.
module sync2 (
  input  logic clkin,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; both are cleared by reset so lock reads low afterwards.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_rst_seq.sv
// PLL bring-up sequencer: holds the PLL in reset, waits for lock with a
// bounded number of retries, qualifies lock stability, then releases the
// system reset. Gives up into FAIL until rearmed.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// PLLRST   | PLL reset asserted for PLL_RST_CYCLES cycles
// WAITLOCK | PLL released, waiting up to LOCK_TIMEOUT cycles for lock
// STABLE   | lock seen, must stay high STABLE_CYCLES cycles
// RUN      | system reset released, ready high
// FAIL     | retries exhausted, PLL held in reset until rearm
module pll_rst_seq #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 24000,
  parameter int STABLE_CYCLES  = 2400,
  parameter int MAX_RETRY      = 7
) (
  input  logic       clkin,
  input  logic       reset_n,
  input  logic       lock,
  input  logic       rearm,
  output logic       pll_reset,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt
);

  import pll_rst_seq_pkg::*;

  localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CYC = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRY);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [3:0]       retry_nx;
  logic             lock_s;

  sync2 u_sync2 (
    .clkin   (clkin),
    .reset_n (reset_n),
    .d       (lock),
    .q       (lock_s)
  );

  // Next-state, shared counter and retry bookkeeping. Every state change
  // clears cnt so each state times itself from zero; lock loss is tested
  // before any terminal count so it always wins a tie.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CNT_ONE;
    retry_nx = retry_cnt;
    unique case (state)
      PLLRST: begin
        if (cnt == RST_LAST) begin
          state_nx = WAITLOCK;
          cnt_nx   = '0;
        end
      end
      WAITLOCK: begin
        if (lock_s) begin
          state_nx = STABLE;
          cnt_nx   = '0;
        end else if (cnt == LOCK_LAST) begin
          cnt_nx = '0;
          if (retry_cnt == RETRY_MAX) begin
            state_nx = FAIL;
          end else begin
            state_nx = PLLRST;
            retry_nx = retry_cnt + 4'd1;
          end
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_nx = WAITLOCK;
          cnt_nx   = '0;
        end else if (cnt == STAB_LAST) begin
          state_nx = RUN;
          cnt_nx   = '0;
          retry_nx = '0;
        end
      end
      RUN: begin
        cnt_nx = '0;
        if (!lock_s) state_nx = PLLRST;
      end
      FAIL: begin
        cnt_nx = '0;
        if (rearm) begin
          state_nx = PLLRST;
          retry_nx = '0;
        end
      end
      default: begin
        state_nx = PLLRST;
        cnt_nx   = '0;
        retry_nx = '0;
      end
    endcase
  end

  // State register with outputs decoded from next state, so they move on the
  // same edge as the state itself.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      state     <= PLLRST;
      cnt       <= '0;
      retry_cnt <= '0;
      pll_reset <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      retry_cnt <= retry_nx;
      pll_reset <= (state_nx == PLLRST) || (state_nx == FAIL);
      sys_rst_n <= (state_nx == RUN);
      ready     <= (state_nx == RUN);
      fail      <= (state_nx == FAIL);
    end
  end

endmodule
